// File: rtl/pacman_pkg.sv
// Shared types and scoring constants for the pacman gameplay status logic.
package pacman_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ALIVE,
    DYING,
    RESPAWN,
    OVER
  } status_state_t;

  localparam int unsigned PTS_PELLET      = 10;
  localparam int unsigned PTS_POWER       = 50;
  localparam int unsigned PTS_GHOST       = 200;
  localparam int unsigned BONUS_THRESHOLD = 10000;
  localparam int unsigned MAX_LIVES       = 7;

  // Counter width able to hold n, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/game_status_tracker_if.sv
// Gameplay event inputs and status outputs exchanged with the game status tracker.
interface game_status_tracker_if;
  logic        frame_tick;
  logic        playon;
  logic        ghost_hit;
  logic        pellet_eaten;
  logic        power_eaten;
  logic        isGameOver;
  logic        won;
  logic [2:0]  lives;
  logic [15:0] score;
  logic        power_on;
  logic        freeze;
  logic        respawn;

  modport master (
    output frame_tick, playon, ghost_hit, pellet_eaten, power_eaten,
    input  isGameOver, won, lives, score, power_on, freeze, respawn
  );

  modport slave (
    input  frame_tick, playon, ghost_hit, pellet_eaten, power_eaten,
    output isGameOver, won, lives, score, power_on, freeze, respawn
  );
endinterface

// File: rtl/frame_countdown.sv
// Loadable down-counter stepping once per video frame; busy while non-zero.
module frame_countdown #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             frame_tick,
  input  logic             enable,
  output logic             busy
);
  logic [WIDTH-1:0] count;

  // A load in the same cycle as a frame tick wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (enable && frame_tick && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign busy = (count != '0);
endmodule

// File: rtl/game_status_tracker.sv
// Tracks lives, score, pellets and power mode; sequences death/respawn and raises isGameOver.
// Optional macro BONUS_LIFE_EN grants one extra life per round when score first reaches 10000.
module game_status_tracker
  import pacman_pkg::*;
#(
  parameter int unsigned START_LIVES  = 3,
  parameter int unsigned PELLET_COUNT = 240,
  parameter int unsigned DEATH_FRAMES = 90,
  parameter int unsigned POWER_FRAMES = 360
) (
  input  logic                 Clk,
  input  logic                 Reset,
  game_status_tracker_if.slave bus
);
  localparam int unsigned DW = cnt_width(DEATH_FRAMES);
  localparam int unsigned PW = cnt_width(POWER_FRAMES);

  status_state_t state, state_next;
  logic [2:0]    lives, lives_next, lives_bonus;
  logic [15:0]   score, score_next;
  logic [8:0]    pellets, pellets_next;
  logic          won, won_next;
`ifdef BONUS_LIFE_EN
  logic          bonus_given, bonus_next;
`endif

  logic          death_load, death_en, death_busy;
  logic          pow_load, pow_en, pow_busy;
  logic [PW-1:0] pow_val;

  logic [8:0]    eat_cnt;
  logic [16:0]   score_sum;
  logic          power_eff, win, lethal;

  // A power pellet eaten this cycle already makes a simultaneous ghost edible.
  assign power_eff = pow_busy || bus.power_eaten;
  assign eat_cnt   = 9'(bus.pellet_eaten) + 9'(bus.power_eaten);
  assign score_sum = {1'b0, score}
                   + (bus.pellet_eaten ? 17'(PTS_PELLET) : 17'd0)
                   + (bus.power_eaten  ? 17'(PTS_POWER)  : 17'd0)
                   + ((bus.ghost_hit && power_eff) ? 17'(PTS_GHOST) : 17'd0);
  assign win       = (eat_cnt != '0) && (pellets <= eat_cnt);
  assign lethal    = bus.ghost_hit && !power_eff && !win;

  always_comb begin
    state_next   = state;
    lives_next   = lives;
    lives_bonus  = lives;
    score_next   = score;
    pellets_next = pellets;
    won_next     = won;
    death_load   = 1'b0;
    death_en     = 1'b0;
    pow_load     = 1'b0;
    pow_en       = 1'b0;
    pow_val      = '0;
`ifdef BONUS_LIFE_EN
    bonus_next   = bonus_given;
`endif
    case (state)
      IDLE: begin
        if (bus.playon) begin
          state_next   = ALIVE;
          lives_next   = 3'(START_LIVES);
          score_next   = '0;
          pellets_next = 9'(PELLET_COUNT);
          won_next     = 1'b0;
          pow_load     = 1'b1;
`ifdef BONUS_LIFE_EN
          bonus_next   = 1'b0;
`endif
        end
      end
      ALIVE: begin
        if (!bus.playon) begin
          state_next = IDLE;
          pow_load   = 1'b1;
        end else begin
          pow_en       = 1'b1;
          score_next   = score_sum[16] ? 16'hFFFF : score_sum[15:0];
          pellets_next = (pellets <= eat_cnt) ? '0 : pellets - eat_cnt;
`ifdef BONUS_LIFE_EN
          if (!bonus_given && (score < 16'(BONUS_THRESHOLD)) &&
              (score_next >= 16'(BONUS_THRESHOLD))) begin
            bonus_next = 1'b1;
            if (lives != 3'(MAX_LIVES)) lives_bonus = lives + 3'd1;
          end
`endif
          lives_next = lives_bonus;
          if (bus.power_eaten) begin
            pow_load = 1'b1;
            pow_val  = PW'(POWER_FRAMES);
          end
          if (win) begin
            won_next   = 1'b1;
            state_next = OVER;
          end else if (lethal) begin
            lives_next = lives_bonus - 3'd1;
            pow_load   = 1'b1;
            pow_val    = '0;
            if (lives_bonus == 3'd1) begin
              state_next = OVER;
            end else begin
              state_next = DYING;
              death_load = 1'b1;
            end
          end
        end
      end
      DYING: begin
        if (!bus.playon) begin
          state_next = IDLE;
        end else begin
          death_en = 1'b1;
          if (!death_busy) state_next = RESPAWN;
        end
      end
      RESPAWN: state_next = bus.playon ? ALIVE : IDLE;
      OVER: begin
        if (!bus.playon) begin
          state_next = IDLE;
          won_next   = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state       <= IDLE;
      lives       <= '0;
      score       <= '0;
      pellets     <= '0;
      won         <= 1'b0;
`ifdef BONUS_LIFE_EN
      bonus_given <= 1'b0;
`endif
    end else begin
      state       <= state_next;
      lives       <= lives_next;
      score       <= score_next;
      pellets     <= pellets_next;
      won         <= won_next;
`ifdef BONUS_LIFE_EN
      bonus_given <= bonus_next;
`endif
    end
  end

  frame_countdown #(.WIDTH(DW)) u_death (
    .clk        (Clk),
    .rst_n      (Reset),
    .load       (death_load),
    .load_val   (DW'(DEATH_FRAMES)),
    .frame_tick (bus.frame_tick),
    .enable     (death_en),
    .busy       (death_busy)
  );

  frame_countdown #(.WIDTH(PW)) u_power (
    .clk        (Clk),
    .rst_n      (Reset),
    .load       (pow_load),
    .load_val   (pow_val),
    .frame_tick (bus.frame_tick),
    .enable     (pow_en),
    .busy       (pow_busy)
  );

  assign bus.isGameOver = (state == OVER);
  assign bus.won        = won;
  assign bus.lives      = lives;
  assign bus.score      = score;
  assign bus.power_on   = pow_busy;
  assign bus.freeze     = (state == DYING);
  assign bus.respawn    = (state == RESPAWN);
endmodule

// File: tb/tb_game_status_tracker.sv
// Bench for game_status_tracker: directed scenarios plus random events against a round-level model.
module tb_game_status_tracker;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic playon = 1'b0, tick = 1'b0, gh = 1'b0, pe = 1'b0, pw = 1'b0;

  always #5 clk = ~clk;

  game_status_tracker_if bus_a ();
  game_status_tracker_if bus_b ();

  assign bus_a.playon       = playon;
  assign bus_a.frame_tick   = tick;
  assign bus_a.ghost_hit    = gh;
  assign bus_a.pellet_eaten = pe;
  assign bus_a.power_eaten  = pw;
  assign bus_b.playon       = playon;
  assign bus_b.frame_tick   = tick;
  assign bus_b.ghost_hit    = gh;
  assign bus_b.pellet_eaten = pe;
  assign bus_b.power_eaten  = pw;

  game_status_tracker u_dut (
    .Clk   (clk),
    .Reset (rst_n),
    .bus   (bus_a)
  );

  game_status_tracker #(
    .START_LIVES  (3),
    .PELLET_COUNT (2),
    .DEATH_FRAMES (3),
    .POWER_FRAMES (5)
  ) u_small (
    .Clk   (clk),
    .Reset (rst_n),
    .bus   (bus_b)
  );

  typedef struct {
    int lives, score, pellets, power, death;
    bit won, over, live, dying, resp, bonus;
  } mdl_t;

  typedef struct {
    int lives, pellets, death, power;
  } cfg_t;

  mdl_t ma, mb;
  cfg_t ca, cb;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Round-level reference: flags for in-play / dying / over, frame counts as plain integers.
  function automatic mdl_t step(input mdl_t m, input cfg_t c);
    mdl_t n = m;
    int   eaten;
    int   s;
    bit   powered;
    n.resp = 0;
    if (m.over) begin
      if (!playon) begin
        n.over = 0;
        n.won  = 0;
      end
    end else if (!(m.live || m.dying || m.resp)) begin
      if (playon) begin
        n.live = 1; n.lives = c.lives; n.score = 0; n.pellets = c.pellets;
        n.won = 0; n.power = 0; n.bonus = 0;
      end
    end else if (!playon) begin
      n.live = 0; n.dying = 0; n.power = 0;
    end else if (m.resp) begin
      n.live = 1;
    end else if (m.dying) begin
      if (m.death == 0) begin
        n.dying = 0;
        n.resp  = 1;
      end else if (tick) begin
        n.death = m.death - 1;
      end
    end else begin
      eaten   = (pe ? 1 : 0) + (pw ? 1 : 0);
      powered = (m.power > 0) || pw;
      s = m.score + (pe ? 10 : 0) + (pw ? 50 : 0) + ((gh && powered) ? 200 : 0);
      if (s > 65535) s = 65535;
      n.score   = s;
      n.pellets = (m.pellets > eaten) ? m.pellets - eaten : 0;
`ifdef BONUS_LIFE_EN
      if (!m.bonus && m.score < 10000 && s >= 10000) begin
        n.bonus = 1;
        if (n.lives < 7) n.lives = n.lives + 1;
      end
`endif
      if (pw) n.power = c.power;
      else if (tick && m.power > 0) n.power = m.power - 1;
      if (eaten > 0 && m.pellets <= eaten) begin
        n.won = 1; n.over = 1; n.live = 0;
      end else if (gh && !powered) begin
        n.lives = n.lives - 1; n.power = 0; n.live = 0;
        if (n.lives == 0) n.over = 1;
        else begin
          n.dying = 1;
          n.death = c.death;
        end
      end
    end
    return n;
  endfunction

  task automatic check_outputs(input string who, input logic go, input logic w, input logic [2:0] lv,
                               input logic [15:0] sc, input logic pon, input logic fr,
                               input logic rs, input mdl_t m);
    check({who, ".isGameOver"}, 32'(go), 32'(m.over));
    check({who, ".won"}, 32'(w), 32'(m.won));
    check({who, ".lives"}, 32'(lv), m.lives);
    check({who, ".score"}, 32'(sc), m.score);
    check({who, ".power_on"}, 32'(pon), 32'(m.power > 0));
    check({who, ".freeze"}, 32'(fr), 32'(m.dying));
    check({who, ".respawn"}, 32'(rs), 32'(m.resp));
  endtask

  task automatic check_all();
    check_outputs("a", bus_a.isGameOver, bus_a.won, bus_a.lives, bus_a.score,
                  bus_a.power_on, bus_a.freeze, bus_a.respawn, ma);
    check_outputs("b", bus_b.isGameOver, bus_b.won, bus_b.lives, bus_b.score,
                  bus_b.power_on, bus_b.freeze, bus_b.respawn, mb);
  endtask

  // Called at a negedge; returns at the following negedge after checking both DUTs.
  task automatic drive(input logic t, input logic g, input logic p, input logic w);
    tick = t; gh = g; pe = p; pw = w;
    @(posedge clk);
    if (rst_n) begin
      ma = step(ma, ca);
      mb = step(mb, cb);
    end
    @(negedge clk);
    check_all();
    tick = 1'b0; gh = 1'b0; pe = 1'b0; pw = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ma = '{default: 0};
    mb = '{default: 0};
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
  endtask

  task automatic wait_alive();
    for (int i = 0; i < 400 && (bus_a.freeze || bus_a.respawn); i++) drive(1'b1, 1'b0, 1'b0, 1'b0);
    check("wait_alive_timeout", 32'(bus_a.freeze | bus_a.respawn), 0);
  endtask

  initial begin
    int n;
    ca = '{lives: 3, pellets: 240, death: 90, power: 360};
    cb = '{lives: 3, pellets: 2, death: 3, power: 5};
    ma = '{default: 0};
    mb = '{default: 0};
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // Reset asserted in the middle of a round
    playon = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (12) drive(1'b0, 1'b0, 1'b1, 1'b0);
    check("pre_reset_score", 32'(bus_a.score), 120);
    do_reset();
    check("rst_over", 32'(bus_a.isGameOver), 0);
    check("rst_score", 32'(bus_a.score), 0);
    check("rst_lives", 32'(bus_a.lives), 0);
    check("rst_power", 32'(bus_a.power_on), 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("start_lives", 32'(bus_a.lives), 3);
    check("start_score", 32'(bus_a.score), 0);

    // Pellets, power pellet, edible ghost, power expiry
    repeat (3) drive(1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    check("power_score", 32'(bus_a.score), 80);
    check("power_on", 32'(bus_a.power_on), 1);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    check("ghost_eat_score", 32'(bus_a.score), 280);
    check("ghost_eat_lives", 32'(bus_a.lives), 3);
    check("ghost_eat_freeze", 32'(bus_a.freeze), 0);
    repeat (359) drive(1'b1, 1'b0, 1'b0, 1'b0);
    check("power_before_end", 32'(bus_a.power_on), 1);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    check("power_expired", 32'(bus_a.power_on), 0);

    // Lethal hit, death animation length, single-cycle respawn
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    check("death_lives", 32'(bus_a.lives), 2);
    check("death_freeze", 32'(bus_a.freeze), 1);
    n = 0;
    while (bus_a.freeze && n < 200) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      n++;
      drive(1'b0, 1'b0, 1'b0, 1'b0);
    end
    check("death_frames", n, 90);
    check("respawn_pulse", 32'(bus_a.respawn), 1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("respawn_single", 32'(bus_a.respawn), 0);
    check("respawn_unfreeze", 32'(bus_a.freeze), 0);

    // Last life lost
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    check("second_death_lives", 32'(bus_a.lives), 1);
    wait_alive();
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    check("over_flag", 32'(bus_a.isGameOver), 1);
    check("over_won", 32'(bus_a.won), 0);
    check("over_lives", 32'(bus_a.lives), 0);
    repeat (5) drive(1'b1, 1'b1, 1'b1, 1'b1);
    check("over_hold", 32'(bus_a.isGameOver), 1);
    check("over_hold_score", 32'(bus_a.score), 280);
    playon = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("over_exit", 32'(bus_a.isGameOver), 0);
    check("idle_score_hold", 32'(bus_a.score), 280);

    // Board clear beats a lethal hit in the same cycle (small board)
    playon = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    check("clear_first_score", 32'(bus_b.score), 10);
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    check("clear_won", 32'(bus_b.won), 1);
    check("clear_over", 32'(bus_b.isGameOver), 1);
    check("clear_lives", 32'(bus_b.lives), 3);
    check("clear_score", 32'(bus_b.score), 20);

    // Score saturation via repeated edible ghosts
    playon = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    playon = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (340) drive(1'b0, 1'b1, 1'b0, 1'b0);
    check("sat_score_a", 32'(bus_a.score), 65535);
    check("sat_score_b", 32'(bus_b.score), 65535);

    // Random gameplay
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 2999) == 0) do_reset();
      if (playon) begin
        if ($urandom_range(0, 199) == 0) playon = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        playon = 1'b1;
      end
      drive($urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, 5) == 0, $urandom_range(0, 29) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
